capture_ctrl_mc: RTL and testbench
==================================

Name: capture_ctrl_mc

Overview:
Multi-channel, parametrised capture/dump controller for the logic-analyser sample RAMs. It writes decimated samples into a circular buffer shared by NUM_CH channel RAMs, with a programmable pre/post-trigger split. After capture it dumps one selected channel, oldest sample first, over a valid/ready handshake to the command/UART layer. It replaces the fixed 9-bit, rclk-phased controller: RAMs here are single-clock synchronous with 1-cycle read latency.

Parameters:
ADDR_W, 9, RAM address width; DEPTH = 2**ADDR_W samples per channel
NUM_CH, 3, number of channel RAMs sharing address/we
DEC_W, 4, width of dec_pwr; decimation counter is 2**DEC_W bits wide
CH_W, 2, width of dump_ch (>= clog2(NUM_CH))

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous, active-low reset
trig_in  in  1  qualified, synchronous trigger pulse
trig_mode  in  2  00 off, 01 normal, 10 auto, 11 single (normal, and no rearm until capture_done cleared)
trig_pos  in  ADDR_W  number of post-trigger samples, 0..DEPTH-1
dec_pwr  in  DEC_W  keep 1 of every 2**dec_pwr clocks
capture_done  in  1  status bit from the register file; 1 blocks a new capture
set_capture_done  out  1  1-cycle pulse at capture completion
armed  out  1  pre-trigger fill complete, trigger accepted
triggered  out  1  trigger seen; high from trigger until capture end
start_dump  in  1  1-cycle dump request
dump_ch  in  CH_W  channel to dump; sampled on start_dump
ram_addr  out  ADDR_W  shared RAM address
ram_we  out  1  shared write enable
ram_en  out  NUM_CH  per-channel enable
dump_valid  out  1  RAM read data of selected channel valid
dump_ready  in  1  consumer accepts current sample
dump_finished  out  1  1-cycle pulse after the last sample is accepted

Behaviour:
- Reset: state IDLE. wr_ptr, rd_ptr, counters = 0. All outputs 0.
- Decimator: dec_cnt clears on capture start and on every keep. keep = (dec_cnt == 2**dec_pwr - 1). dec_pwr=0 gives keep every cycle.
- Sample write, on keep in PRE/ARMED/POST: ram_en = all 1s, ram_we = 1, ram_addr = wr_ptr, then wr_ptr+1. wr_ptr wraps DEPTH-1 -> 0.
- IDLE:
  - start_dump has priority: latch dump_ch, rd_ptr = wr_ptr (oldest sample), dcnt = DEPTH-1, -> DUMP_RD.
  - Else if !capture_done and trig_mode != 00: pre_cnt = DEPTH - trig_pos (ADDR_W+1 bits), -> PRE.
- PRE: each write decrements pre_cnt. On the write that makes it 0: -> ARMED, armed = 1. Triggers in PRE are ignored.
- ARMED:
  - A trig_in on any cycle (not only keep cycles) -> POST, triggered = 1, post_cnt = trig_pos.
  - Auto mode: auto_cnt counts writes in ARMED. Reaching DEPTH forces a trigger identically.
  - trig_pos = 0: trigger goes straight to completion.
- POST: each write decrements post_cnt. On the write reaching 0 (or immediately if it was 0): -> IDLE, set_capture_done pulse, armed = 0, triggered = 0.
- trig_mode = 00 in PRE/ARMED/POST: abort to IDLE. No set_capture_done; armed and triggered clear.
- start_dump outside IDLE is ignored.
- DUMP_RD: ram_en[dump_ch_q] = 1, ram_addr = rd_ptr, -> DUMP_SEND.
- DUMP_SEND: ram_en[dump_ch_q] held, ram_addr held, dump_valid = 1 until dump_ready.
  - On valid & ready with dcnt = 0: dump_finished pulse, -> IDLE.
  - Otherwise: rd_ptr+1 (wrapping), dcnt-1, -> DUMP_RD.
  - Per-sample throughput is 2 cycles minimum.
- dump_ready while !dump_valid has no effect. wr_ptr is unchanged by a dump, so repeated dumps return identical data.
- ram_we is never 1 in dump states. Only one channel bit of ram_en is set during a dump.
- Async reset mid-capture or mid-dump: immediate return to IDLE with all outputs 0.

Test Plan:
- ADDR_W=4, dec_pwr=0, trig_mode=01, trig_pos=4, trig_in at cycle 30 -> armed after 12 writes; exactly 4 further writes; set_capture_done pulses once; wr_ptr advances by writes mod 16.
- Dump ch 2 after the capture above, dump_ready tied 1 -> 16 valid beats; addresses start at the final wr_ptr and wrap; only ram_en[2] high; dump_finished pulses after beat 16.
- dec_pwr=3 -> ram_we strobes exactly every 8 clocks; trig_in between strobes is still accepted.
- trig_mode=10, no trig_in, trig_pos=0, ADDR_W=4 -> forced trigger after 16 armed writes; completes immediately.
- Random dump_ready backpressure -> dump_valid and ram_addr stable while stalled; no sample dropped or duplicated.
- trig_mode forced to 00 in ARMED; start_dump during POST; capture_done=1 in IDLE -> abort with no completion pulse; dump ignored; no capture starts.

Source files
------------

// File: rtl/capture_ctrl_mc.sv
// Capture/dump controller for the logic-analyser sample RAMs: decimated circular
// capture with a programmable pre/post-trigger split, then an oldest-first channel dump.
module capture_ctrl_mc #(
  parameter int ADDR_W = 9,
  parameter int NUM_CH = 3,
  parameter int DEC_W  = 4,
  parameter int CH_W   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              trig_in,
  input  logic [1:0]        trig_mode,
  input  logic [ADDR_W-1:0] trig_pos,
  input  logic [DEC_W-1:0]  dec_pwr,
  input  logic              capture_done,
  output logic              set_capture_done,
  output logic              armed,
  output logic              triggered,
  input  logic              start_dump,
  input  logic [CH_W-1:0]   dump_ch,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [NUM_CH-1:0] ram_en,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic              dump_finished
);

  localparam int DEPTH  = 2 ** ADDR_W;
  localparam int DEC_CW = 2 ** DEC_W;
  localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [2:0] {IDLE, PRE, ARMED, POST, DUMP_RD, DUMP_SEND} state_t;

  state_t              state, state_nx;
  logic [ADDR_W-1:0]   wr_ptr, wr_ptr_nx, rd_ptr, rd_ptr_nx;
  logic [ADDR_W-1:0]   dcnt, dcnt_nx, post_cnt, post_cnt_nx;
  logic [ADDR_W:0]     pre_cnt, pre_cnt_nx, auto_cnt, auto_cnt_nx;
  logic [DEC_CW-1:0]   dec_cnt, dec_cnt_nx, keep_val;
  logic [CH_W-1:0]     dump_ch_q, dump_ch_nx;
  logic                armed_nx, triggered_nx, finished_nx;
  logic                keep, capturing, write, abort, trig_now;

  assign keep_val  = (DEC_CW'(1) << dec_pwr) - DEC_CW'(1);
  assign keep      = (dec_cnt == keep_val);
  assign capturing = (state == PRE) || (state == ARMED) || (state == POST);
  assign write     = capturing && keep;
  assign abort     = (trig_mode == 2'b00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      dcnt          <= '0;
      post_cnt      <= '0;
      pre_cnt       <= '0;
      auto_cnt      <= '0;
      dec_cnt       <= '0;
      dump_ch_q     <= '0;
      armed         <= 1'b0;
      triggered     <= 1'b0;
      dump_finished <= 1'b0;
    end else begin
      state         <= state_nx;
      wr_ptr        <= wr_ptr_nx;
      rd_ptr        <= rd_ptr_nx;
      dcnt          <= dcnt_nx;
      post_cnt      <= post_cnt_nx;
      pre_cnt       <= pre_cnt_nx;
      auto_cnt      <= auto_cnt_nx;
      dec_cnt       <= dec_cnt_nx;
      dump_ch_q     <= dump_ch_nx;
      armed         <= armed_nx;
      triggered     <= triggered_nx;
      dump_finished <= finished_nx;
    end
  end

  // set_capture_done is combinational so the register file sets capture_done on the
  // same edge the FSM reaches IDLE, preventing an immediate re-arm.
  always_comb begin
    state_nx         = state;
    wr_ptr_nx        = wr_ptr;
    rd_ptr_nx        = rd_ptr;
    dcnt_nx          = dcnt;
    post_cnt_nx      = post_cnt;
    pre_cnt_nx       = pre_cnt;
    auto_cnt_nx      = auto_cnt;
    dec_cnt_nx       = capturing ? (keep ? '0 : dec_cnt + DEC_CW'(1)) : '0;
    dump_ch_nx       = dump_ch_q;
    armed_nx         = armed;
    triggered_nx     = triggered;
    finished_nx      = 1'b0;
    set_capture_done = 1'b0;
    ram_addr         = '0;
    ram_we           = 1'b0;
    ram_en           = '0;
    dump_valid       = 1'b0;
    trig_now         = 1'b0;

    if (write) begin
      ram_we    = 1'b1;
      ram_en    = '1;
      ram_addr  = wr_ptr;
      wr_ptr_nx = wr_ptr + ADDR_W'(1);
    end

    case (state)
      IDLE: begin
        if (start_dump) begin
          dump_ch_nx = dump_ch;
          rd_ptr_nx  = wr_ptr;
          dcnt_nx    = '1;
          state_nx   = DUMP_RD;
        end else if (!capture_done && !abort) begin
          pre_cnt_nx = DEPTH_V - {1'b0, trig_pos};
          state_nx   = PRE;
        end
      end
      PRE: begin
        if (abort) begin
          state_nx = IDLE;
          armed_nx = 1'b0;
        end else if (write) begin
          pre_cnt_nx = pre_cnt - (ADDR_W + 1)'(1);
          if (pre_cnt == (ADDR_W + 1)'(1)) begin
            state_nx    = ARMED;
            armed_nx    = 1'b1;
            auto_cnt_nx = '0;
          end
        end
      end
      ARMED: begin
        if (abort) begin
          state_nx     = IDLE;
          armed_nx     = 1'b0;
          triggered_nx = 1'b0;
        end else begin
          if (write) auto_cnt_nx = auto_cnt + (ADDR_W + 1)'(1);
          // Auto mode forces the trigger on the write that fills the whole buffer.
          trig_now = trig_in ||
                     ((trig_mode == 2'b10) && write && (auto_cnt == DEPTH_V - (ADDR_W + 1)'(1)));
          if (trig_now) begin
            if (trig_pos == '0) begin
              state_nx         = IDLE;
              set_capture_done = 1'b1;
              armed_nx         = 1'b0;
              triggered_nx     = 1'b0;
            end else begin
              state_nx     = POST;
              triggered_nx = 1'b1;
              post_cnt_nx  = trig_pos;
            end
          end
        end
      end
      POST: begin
        if (abort) begin
          state_nx     = IDLE;
          armed_nx     = 1'b0;
          triggered_nx = 1'b0;
        end else if ((post_cnt == '0) || (write && (post_cnt == ADDR_W'(1)))) begin
          state_nx         = IDLE;
          set_capture_done = 1'b1;
          armed_nx         = 1'b0;
          triggered_nx     = 1'b0;
        end else if (write) begin
          post_cnt_nx = post_cnt - ADDR_W'(1);
        end
      end
      DUMP_RD: begin
        for (int i = 0; i < NUM_CH; i++) ram_en[i] = (dump_ch_q == CH_W'(i));
        ram_addr = rd_ptr;
        state_nx = DUMP_SEND;
      end
      DUMP_SEND: begin
        for (int i = 0; i < NUM_CH; i++) ram_en[i] = (dump_ch_q == CH_W'(i));
        ram_addr   = rd_ptr;
        dump_valid = 1'b1;
        if (dump_ready) begin
          if (dcnt == '0) begin
            finished_nx = 1'b1;
            state_nx    = IDLE;
          end else begin
            rd_ptr_nx = rd_ptr + ADDR_W'(1);
            dcnt_nx   = dcnt - ADDR_W'(1);
            state_nx  = DUMP_RD;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_capture_ctrl_mc.sv
// Self-checking bench for capture_ctrl_mc (ADDR_W=4): RAM and register-file models,
// a write monitor, and a queue scoreboard for dumped samples.
module tb_capture_ctrl_mc;

  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int NCH   = 3;

  logic       clk = 1'b0;
  logic       rst_n, trig_in, capture_done, start_dump, dump_ready;
  logic [1:0] trig_mode, dump_ch;
  logic [3:0] trig_pos, dec_pwr;
  logic       set_capture_done, armed, triggered, ram_we, dump_valid, dump_finished;
  logic [3:0] ram_addr;
  logic [2:0] ram_en;

  always #5 clk = ~clk;

  capture_ctrl_mc #(.ADDR_W(AW), .NUM_CH(NCH), .DEC_W(4), .CH_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .trig_in(trig_in), .trig_mode(trig_mode),
    .trig_pos(trig_pos), .dec_pwr(dec_pwr), .capture_done(capture_done),
    .set_capture_done(set_capture_done), .armed(armed), .triggered(triggered),
    .start_dump(start_dump), .dump_ch(dump_ch), .ram_addr(ram_addr), .ram_we(ram_we),
    .ram_en(ram_en), .dump_valid(dump_valid), .dump_ready(dump_ready),
    .dump_finished(dump_finished)
  );

  // Register-file model: completion sets capture_done, software clears it.
  logic done_reg, clr_done, hold_done;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) done_reg <= 1'b0;
    else if (set_capture_done) done_reg <= 1'b1;
    else if (clr_done) done_reg <= 1'b0;
  end
  assign capture_done = done_reg | hold_done;

  // Channel RAMs: data tags the channel and the write sequence number.
  logic [15:0] mem [NCH][DEPTH];
  logic [15:0] rdata [4];
  int seq_p = 0;
  always @(posedge clk) begin
    if (ram_we) begin
      for (int c = 0; c < NCH; c++)
        if (ram_en[c]) mem[c][ram_addr] <= {4'(c), seq_p[11:0]};
      seq_p <= seq_p + 1;
    end
    for (int c = 0; c < NCH; c++)
      if (ram_en[c]) rdata[c] <= mem[c][ram_addr];
  end

  // Write monitor and reference write pointer.
  logic [1:0] dump_sel;
  int wr_total = 0, addr_err = 0, done_cnt = 0, fin_cnt = 0, en_err = 0, stall_err = 0;
  int armed_at = -1, trig_at = -1;
  int shadow [DEPTH];
  logic [3:0]  exp_wa = 4'd0, prev_addr = 4'd0;
  logic [15:0] prev_data = 16'd0;
  logic prev_armed = 1'b0, prev_trig = 1'b0, prev_stall = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_wa     <= 4'd0;
      prev_armed <= 1'b0;
      prev_trig  <= 1'b0;
      prev_stall <= 1'b0;
    end else begin
      if (armed && !prev_armed) armed_at <= wr_total;
      if (triggered && !prev_trig) trig_at <= wr_total;
      prev_armed <= armed;
      prev_trig  <= triggered;
      if (ram_we) begin
        if (ram_addr !== exp_wa || ram_en !== 3'b111) addr_err <= addr_err + 1;
        shadow[exp_wa] <= wr_total;
        exp_wa         <= exp_wa + 4'd1;
        wr_total       <= wr_total + 1;
      end
      if (set_capture_done) done_cnt <= done_cnt + 1;
      if (dump_finished) fin_cnt <= fin_cnt + 1;
      if ((ram_we && dump_valid) ||
          (!ram_we && ram_en !== 3'b000 && ram_en !== (3'b001 << dump_sel)))
        en_err <= en_err + 1;
      if (prev_stall && (!dump_valid || ram_addr !== prev_addr || rdata[dump_sel] !== prev_data))
        stall_err <= stall_err + 1;
      prev_stall <= dump_valid && !dump_ready;
      prev_addr  <= ram_addr;
      prev_data  <= rdata[dump_sel];
    end
  end

  typedef struct packed { logic [3:0] addr; logic [15:0] data; } beat_t;
  beat_t sb [$];

  int checks = 0, errors = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_done();
    clr_done = 1'b1;
    tick();
    clr_done = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({set_capture_done, armed, triggered, ram_we, dump_valid, dump_finished} !== 6'b0) begin
      errors++;
      $display("[TB] FAIL reset_flags: got %b expected 000000",
               {set_capture_done, armed, triggered, ram_we, dump_valid, dump_finished});
    end
    checks++;
    if (ram_addr !== 4'd0) begin
      errors++; $display("[TB] FAIL reset_addr: got %0d expected 0", ram_addr);
    end
    checks++;
    if (ram_en !== 3'b000) begin
      errors++; $display("[TB] FAIL reset_en: got %b expected 000", ram_en);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_capture_normal();
    int w0 = wr_total, d0 = done_cnt, a0 = addr_err;
    dec_pwr = 4'd0; trig_pos = 4'd4; trig_mode = 2'b01;
    repeat (30) tick();
    trig_in = 1'b1;
    tick();
    trig_in = 1'b0;
    for (int n = 0; n < 100 && done_cnt == d0; n++) tick();
    trig_mode = 2'b00;
    repeat (5) tick();
    checks++;
    if (done_cnt - d0 != 1) begin
      errors++; $display("[TB] FAIL normal_done_pulses: got %0d expected 1", done_cnt - d0);
    end
    checks++;
    if (armed_at - w0 != 12) begin
      errors++; $display("[TB] FAIL normal_armed_writes: got %0d expected 12", armed_at - w0);
    end
    checks++;
    if (trig_at - w0 != 30) begin
      errors++; $display("[TB] FAIL normal_trigger_writes: got %0d expected 30", trig_at - w0);
    end
    checks++;
    if (wr_total - w0 != 34) begin
      errors++; $display("[TB] FAIL normal_total_writes: got %0d expected 34", wr_total - w0);
    end
    checks++;
    if (addr_err != a0) begin
      errors++; $display("[TB] FAIL normal_write_addr: got %0d bad writes expected 0", addr_err - a0);
    end
    checks++;
    if (armed !== 1'b0 || triggered !== 1'b0) begin
      errors++; $display("[TB] FAIL normal_flags_cleared: got %b%b expected 00", armed, triggered);
    end
  endtask

  task automatic test_dump(input int ch, input bit random_ready, input string name);
    beat_t b;
    logic [3:0] a;
    int f0 = fin_cnt, e0 = en_err, s0 = stall_err, beats = 0;
    bit fin = 1'b0;
    sb.delete();
    for (int i = 0; i < DEPTH; i++) begin
      a = exp_wa + 4'(i);
      b.addr = a;
      b.data = {4'(ch), 12'(shadow[a])};
      sb.push_back(b);
    end
    dump_sel   = 2'(ch);
    dump_ch    = 2'(ch);
    dump_ready = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    start_dump = 1'b1;
    tick();
    start_dump = 1'b0;
    for (int n = 0; n < 400 && !fin; n++) begin
      @(negedge clk);
      if (dump_valid && dump_ready) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL %s_extra_beat: got beat %0d expected %0d beats", name, beats + 1, DEPTH);
        end else begin
          b = sb.pop_front();
          checks++;
          if (ram_addr !== b.addr) begin
            errors++; $display("[TB] FAIL %s_addr beat %0d: got %0d expected %0d", name, beats, ram_addr, b.addr);
          end
          checks++;
          if (rdata[ch] !== b.data) begin
            errors++; $display("[TB] FAIL %s_data beat %0d: got %h expected %h", name, beats, rdata[ch], b.data);
          end
        end
        beats++;
      end
      if (dump_finished) fin = 1'b1;
      tick();
      if (random_ready) dump_ready = 1'($urandom_range(0, 1));
    end
    dump_ready = 1'b0;
    tick();
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("[TB] FAIL %s_missing_beats: got %0d left expected 0", name, sb.size());
    end
    checks++;
    if (fin_cnt - f0 != 1) begin
      errors++; $display("[TB] FAIL %s_finished_pulses: got %0d expected 1", name, fin_cnt - f0);
    end
    checks++;
    if (en_err != e0) begin
      errors++; $display("[TB] FAIL %s_enables: got %0d bad cycles expected 0", name, en_err - e0);
    end
    checks++;
    if (stall_err != s0) begin
      errors++; $display("[TB] FAIL %s_stall_stable: got %0d unstable cycles expected 0", name, stall_err - s0);
    end
  endtask

  task automatic test_decimation();
    int w0, cyc = 0, last = -1, bad = 0, post_wr = 0;
    bit fired = 1'b0, done = 1'b0;
    clear_done();
    w0 = wr_total;
    dec_pwr = 4'd3; trig_pos = 4'd4; trig_mode = 2'b01;
    for (int n = 0; n < 600 && !done; n++) begin
      @(negedge clk);
      if (ram_we) begin
        if (last >= 0 && cyc - last != 8) bad++;
        last = cyc;
        if (triggered) post_wr++;
      end
      if (set_capture_done) done = 1'b1;
      tick();
      cyc++;
      trig_in = armed && !triggered && !fired && (cyc - last == 3);
      if (trig_in) fired = 1'b1;
    end
    trig_in = 1'b0; trig_mode = 2'b00;
    tick();
    checks++;
    if (!done || !fired) begin
      errors++; $display("[TB] FAIL dec_completion: got done=%0d fired=%0d expected 1 1", done, fired);
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("[TB] FAIL dec_strobe_spacing: got %0d bad intervals expected 0", bad);
    end
    checks++;
    if (armed_at - w0 != 12) begin
      errors++; $display("[TB] FAIL dec_armed_writes: got %0d expected 12", armed_at - w0);
    end
    checks++;
    if (post_wr != 4) begin
      errors++; $display("[TB] FAIL dec_post_writes: got %0d expected 4", post_wr);
    end
  endtask

  task automatic test_auto();
    int w0, d0, t0;
    clear_done();
    w0 = wr_total; d0 = done_cnt; t0 = trig_at;
    dec_pwr = 4'd0; trig_pos = 4'd0; trig_mode = 2'b10;
    for (int n = 0; n < 200 && done_cnt == d0; n++) tick();
    repeat (5) tick();
    trig_mode = 2'b00;
    checks++;
    if (done_cnt - d0 != 1) begin
      errors++; $display("[TB] FAIL auto_done_pulses: got %0d expected 1", done_cnt - d0);
    end
    checks++;
    if (armed_at - w0 != 16) begin
      errors++; $display("[TB] FAIL auto_armed_writes: got %0d expected 16", armed_at - w0);
    end
    checks++;
    if (wr_total - w0 != 32) begin
      errors++; $display("[TB] FAIL auto_total_writes: got %0d expected 32", wr_total - w0);
    end
    checks++;
    if (trig_at != t0) begin
      errors++; $display("[TB] FAIL auto_no_post: got trig_at %0d expected %0d", trig_at, t0);
    end
  endtask

  task automatic test_abort();
    int d0, f0, w1;
    bit seen = 1'b0, armed_seen = 1'b0, done = 1'b0;
    clear_done();
    d0 = done_cnt;
    dec_pwr = 4'd0; trig_pos = 4'd4; trig_mode = 2'b01;
    for (int n = 0; n < 100 && !armed; n++) tick();
    trig_mode = 2'b00;
    repeat (3) tick();
    w1 = wr_total;
    repeat (5) tick();
    checks++;
    if (armed !== 1'b0 || triggered !== 1'b0 || done_cnt != d0) begin
      errors++; $display("[TB] FAIL abort_state: got armed=%b trig=%b pulses=%0d expected 0 0 0",
                         armed, triggered, done_cnt - d0);
    end
    checks++;
    if (wr_total != w1) begin
      errors++; $display("[TB] FAIL abort_idle_writes: got %0d expected 0", wr_total - w1);
    end
    // Dump request during POST must be dropped.
    f0 = fin_cnt;
    dec_pwr = 4'd2; trig_mode = 2'b01;
    for (int n = 0; n < 200 && !armed; n++) tick();
    trig_in = 1'b1;
    tick();
    trig_in = 1'b0;
    tick();
    start_dump = 1'b1; dump_ch = 2'd1; dump_sel = 2'd1;
    tick();
    start_dump = 1'b0;
    for (int n = 0; n < 100 && !done; n++) begin
      @(negedge clk);
      if (dump_valid) seen = 1'b1;
      if (set_capture_done) done = 1'b1;
      tick();
    end
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (dump_valid) seen = 1'b1;
      tick();
    end
    checks++;
    if (!done) begin
      errors++; $display("[TB] FAIL post_dump_completion: got done=0 expected 1");
    end
    checks++;
    if (seen || fin_cnt != f0) begin
      errors++; $display("[TB] FAIL post_dump_ignored: got valid=%0d fin=%0d expected 0 0", seen, fin_cnt - f0);
    end
    // capture_done is now set: no new capture may start.
    w1 = wr_total;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (armed) armed_seen = 1'b1;
      tick();
    end
    trig_mode = 2'b00;
    checks++;
    if (wr_total != w1 || armed_seen) begin
      errors++; $display("[TB] FAIL done_blocks_capture: got writes=%0d armed=%0d expected 0 0",
                         wr_total - w1, armed_seen);
    end
  endtask

  task automatic test_reset_mid();
    int w1;
    clear_done();
    dec_pwr = 4'd0; trig_pos = 4'd4; trig_mode = 2'b01;
    for (int n = 0; n < 100 && !armed; n++) tick();
    repeat (2) tick();
    checks++;
    if (armed !== 1'b1) begin
      errors++; $display("[TB] FAIL midreset_armed_before: got %b expected 1", armed);
    end
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({set_capture_done, armed, triggered, ram_we, dump_valid, dump_finished, ram_en, ram_addr} !== 13'b0) begin
      errors++; $display("[TB] FAIL midreset_outputs: got %b expected all 0",
                         {set_capture_done, armed, triggered, ram_we, dump_valid, dump_finished, ram_en, ram_addr});
    end
    trig_mode = 2'b00;
    tick();
    rst_n = 1'b1;
    w1 = wr_total;
    repeat (5) tick();
    checks++;
    if (wr_total != w1 || armed !== 1'b0) begin
      errors++; $display("[TB] FAIL midreset_idle: got writes=%0d armed=%b expected 0 0", wr_total - w1, armed);
    end
  endtask

  initial begin
    rst_n = 1'b0; trig_in = 1'b0; trig_mode = 2'b00; trig_pos = 4'd0; dec_pwr = 4'd0;
    start_dump = 1'b0; dump_ch = 2'd0; dump_ready = 1'b0; dump_sel = 2'd0;
    clr_done = 1'b0; hold_done = 1'b0;
    $display("[TB] starting capture_ctrl_mc bench");
    test_reset();
    test_capture_normal();
    test_dump(2, 1'b0, "dump_ch2");
    test_dump(2, 1'b0, "back_to_back_ch2");
    test_decimation();
    test_auto();
    test_dump(0, 1'b1, "backpressure_ch0");
    test_abort();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
